// File: rtl/serial_addsub_sequencer.sv
// Nibble-serial WIDTH-bit adder/subtractor: one 4-bit slice per clock,
// LSB first. Subtract is A + ~B + 1, so Cout=1 means no borrow.
// Ports: clk, rst (sync, active-high), start, A, B, subtract in;
//        busy, done, Result, Cout, Overflow out.
// Option: define ADDSUB_SATURATE_EN to saturate Result on signed overflow.
module serial_addsub_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             subtract,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Overflow
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             carry;
  logic [KW-1:0]    k;
  logic [KW+1:0]    base;
  logic             last;

  logic [3:0] a_sl;
  logic [3:0] b_sl;
  logic [4:0] sum;
  logic       cin_msb;
  logic       ovf_now;

  assign base = {k, 2'b00};
  assign last = (k == KW'(N - 1));

  // Current slice; b is inverted for subtract, +1 enters via carry.
  assign a_sl = a_q[base +: 4];
  assign b_sl = b_q[base +: 4] ^ {4{sub_q}};
  assign sum  = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry};

  // Carry into the top bit of the slice recovered from its sum bit.
  assign cin_msb = sum[3] ^ a_sl[3] ^ b_sl[3];
  assign ovf_now = cin_msb ^ sum[4];

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
      k        <= '0;
      Result   <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            sub_q  <= subtract;
            carry  <= subtract;
            k      <= '0;
            Result <= '0;
          end
        end
        RUN: begin
          Result[base +: 4] <= sum[3:0];
          carry             <= sum[4];
          k                 <= k + 1'b1;
          if (last) begin
            Cout     <= sum[4];
            Overflow <= ovf_now;
`ifdef ADDSUB_SATURATE_EN
            if (ovf_now) begin
              Result <= a_q[WIDTH-1]
                ? {1'b1, {(WIDTH-1){1'b0}}}
                : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
